// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package mem_access_stage_pkg;

    localparam int REG_ADDR_W         = 4;
    localparam int DATA_W             = 16;
    localparam int CTR_W              = 8;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Instruction fields held for the duration of an outstanding access
    typedef struct packed {
        logic                  we;
        logic                  wb_sel;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// Wait-cycle counter; expired asserts once the count reaches LIMIT.
module mem_timeout_ctr
    import mem_access_stage_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CTR_W-1:0] LIMIT_C = CTR_W'(LIMIT);

    logic [CTR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LIMIT_C);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: pass-through for ALU ops, req/ack access to data memory for
// loads/stores with upstream stall and a sticky timeout flag.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  wb_sel_in,
    input  logic                  wr_en_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_sel_out,
    output logic                  wr_en_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [DATA_W-1:0]     mem_out,
    output logic [DATA_W-1:0]     result_out,
    output logic                  stall,
    output logic                  timeout_err
);

    state_t            state, next_state;
    mem_req_t          lat;
    logic [DATA_W-1:0] mem_q;
    logic              start;
    logic              expired;

    assign start = valid_in & (mem_read_in | mem_write_in);

    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != WAIT) | dmem_ack),
        .enable  (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WAIT;
            WAIT:    if (dmem_ack || expired) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat         <= '0;
            mem_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                lat.we     <= mem_write_in & ~mem_read_in;
                lat.wb_sel <= wb_sel_in;
                lat.wr_en  <= wr_en_in;
                lat.rd     <= rd_in;
                lat.result <= result_in;
                lat.wdata  <= store_data_in;
            end
            // Ack wins over an expiry landing in the same cycle
            if (state == WAIT) begin
                if (dmem_ack) begin
                    mem_q <= lat.we ? '0 : dmem_rdata;
                end else if (expired) begin
                    mem_q       <= '0;
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    assign dmem_we    = lat.we;
    assign dmem_addr  = lat.result[ADDR_W-1:0];
    assign dmem_wdata = lat.wdata;

    always_comb begin
        dmem_req   = 1'b0;
        stall      = 1'b0;
        wr_en_out  = 1'b0;
        wb_sel_out = lat.wb_sel;
        rd_out     = lat.rd;
        result_out = lat.result;
        mem_out    = mem_q;
        case (state)
            IDLE: begin
                wb_sel_out = wb_sel_in;
                rd_out     = rd_in;
                result_out = result_in;
                mem_out    = '0;
                stall      = start;
                wr_en_out  = wr_en_in & valid_in & ~start;
            end
            WAIT: begin
                dmem_req = ~expired;
                stall    = 1'b1;
            end
            RESP:    wr_en_out = lat.wr_en;
            default: ;
        endcase
        // Reset must silence the pipeline controls even before state settles
        if (reset) begin
            dmem_req  = 1'b0;
            stall     = 1'b0;
            wr_en_out = 1'b0;
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 16-bit, 16-register pipeline; sits between the EX/MEM pipeline register and the MEM/WB register, and feeds the MEM/WB register directly.
- Performs loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Passes non-memory instructions straight through to MEM/WB.

Parameters:
- ADDR_W, 16, data-memory word-address width; dmem_addr = result_in[ADDR_W-1:0].
- TIMEOUT_CYCLES, 15, maximum WAIT cycles without ack before the access is abandoned (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX/MEM holds a valid instruction.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- wb_sel_in  in  1  write-back select (1 = memory data).
- wr_en_in  in  1  register-file write enable.
- rd_in  in  4  destination register.
- result_in  in  16  ALU result; this is the address for loads and stores.
- store_data_in  in  16  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  16  write data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  16  read data, valid only with dmem_ack.
- wb_sel_out  out  1  to MEM/WB Write_Back_Sel.
- wr_en_out  out  1  to MEM/WB Write_Enable.
- rd_out  out  4  to MEM/WB rd.
- mem_out  out  16  to MEM/WB Mem_Out.
- result_out  out  16  to MEM/WB Result.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- timeout_err  out  1  sticky error flag.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (asynchronous):
  - state=IDLE; all latched fields, mem_out register, timeout counter and timeout_err = 0.
  - While reset is high, dmem_req=0, stall=0 and wr_en_out=0.
- IDLE, no memory op (valid_in=0 or neither mem_read_in nor mem_write_in):
  - Combinational pass-through: wb_sel_out, rd_out and result_out follow their inputs.
  - wr_en_out = wr_en_in & valid_in; mem_out = 0; stall = 0.
- IDLE with valid_in and a memory op:
  - stall=1 combinationally; wr_en_out=0, so a bubble enters MEM/WB.
  - Latch rd, wb_sel, wr_en, result, store data and we at the clock edge. we = mem_write_in & ~mem_read_in; read has priority if both are set.
  - Next state = WAIT.
- WAIT:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the latches and stay stable until ack.
  - stall=1; wr_en_out=0.
  - The counter increments each cycle.
  - On dmem_ack: capture dmem_rdata into mem_out (loads only; stores capture 0), clear the counter, go to RESP.
  - On counter == TIMEOUT_CYCLES with no ack: drop req, set timeout_err, set mem_out=0, go to RESP.
- RESP (exactly 1 cycle):
  - stall=0; outputs are driven from the latches; wr_en_out = latched wr_en. MEM/WB captures at this edge.
  - Next state = IDLE.
  - The new EX/MEM content is evaluated in the following IDLE cycle.
- Latency:
  - A load occupies 2 + N cycles, where N = ack delay in WAIT cycles (N >= 1).
  - Minimum load = 3 cycles: ack arrives in the first WAIT cycle.
- dmem_ack outside WAIT is ignored.
- A late ack after timeout is ignored.
- timeout_err stays set until reset.
- Reset mid-WAIT: req drops immediately, state goes to IDLE, no write-back occurs.
- Upstream inputs may change while stall=1; only the latched values are used.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT, RESP).
  - TIMEOUT_CYCLES default.
  - bit widths: REG_ADDR_W=4, DATA_W=16.
- Sub-module mem_timeout_ctr: 8-bit counter with clear/enable inputs and an expired flag at TIMEOUT_CYCLES.

Test Plan:
- ALU op: valid_in=1, mem_read_in=0, wr_en_in=1, rd_in=5, result_in=16'h0042 -> same cycle wr_en_out=1, rd_out=5, result_out=16'h0042, stall=0, dmem_req=0.
- Load with ack after 3 WAIT cycles: result_in=16'h0010, rdata=16'hBEEF -> stall high for 4 cycles, then RESP with mem_out=16'hBEEF, wr_en_out=1, wb_sel_out=1, rd_out latched; dmem_addr=16'h0010 during WAIT.
- Store: mem_write_in=1, store_data_in=16'h1234, result_in=16'h0020, ack on the first WAIT cycle -> dmem_we=1, dmem_wdata=16'h1234, stall for 2 cycles, RESP wr_en_out=0.
- Timeout: load, ack never arrives -> dmem_req high for 15 cycles then drops; timeout_err=1 and stays high; RESP mem_out=0; a later ack is ignored.
- Reset pulse mid-WAIT -> dmem_req=0 and stall=0 immediately; state is IDLE after release; no wr_en_out pulse.
- Both mem_read_in and mem_write_in set -> treated as a load: dmem_we=0.
